morse_sender: RTL and testbench

- Transmit-side counterpart of the Morse receiver. Accepts one packed 10-bit character code per handshake.
- Plays the code out as timed mark/space intervals on `key`, which gates the tone/LED.
- Emits single-cycle `dot`/`dash`/`interchar`/`interword` event pulses in the same form the receiver consumes. This allows direct loopback testing against the receiver.
- Sits between the character source (keyboard/ROM/FIFO) and the audio/LED output stage.

---
 rtl/morse_sender.sv | 157 +++++++++++++++
 tb/tb_morse_sender.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/morse_sender.sv
// rtl/morse_sender.sv - Morse code transmitter: packed 10-bit code to timed key and event pulses
module morse_sender #(
  parameter int UNIT_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [9:0] data_in,
  output logic       ready,
  output logic       key,
  output logic       dot,
  output logic       dash,
  output logic       interchar,
  output logic       interword,
  output logic       complete
);

  // Counter must hold the longest interval (word gap, 7 units) minus one.
  localparam int CW = (7 * UNIT_CYCLES > 1) ? $clog2(7 * UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] LEN1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LEN3 = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LEN7 = CW'(7 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, CHAR_GAP, WORD_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [2:0]    sym_q, sym_d;
  logic          ready_q, ready_d;
  logic          key_q, key_d;
  logic          dot_q, dot_d;
  logic          dash_q, dash_d;
  logic          ichar_q, ichar_d;
  logic          iword_q, iword_d;
  logic          cmpl_q, cmpl_d;

  function automatic logic sym_valid(input logic [1:0] s);
    return (s == 2'b01) || (s == 2'b10);
  endfunction

  function automatic logic [CW-1:0] mark_len(input logic [1:0] s);
    return (s == 2'b10) ? LEN3 : LEN1;
  endfunction

  // Next-state, interval counter and the next value of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sym_d   = sym_q;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    ichar_d = 1'b0;
    iword_d = 1'b0;
    cmpl_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          shift_d = data_in;
          sym_d   = 3'd0;
          if (data_in == 10'd0) begin
            state_d = WORD_GAP;
            cnt_d   = LEN7;
            iword_d = 1'b1;
          end else if (sym_valid(data_in[1:0])) begin
            state_d = MARK;
            cnt_d   = mark_len(data_in[1:0]);
            dot_d   = (data_in[1:0] == 2'b01);
            dash_d  = (data_in[1:0] == 2'b10);
          end else begin
            // Empty character: nothing to play, just acknowledge it.
            cmpl_d = 1'b1;
          end
        end
      end
      MARK: begin
        if (cnt_q == '0) begin
          shift_d = {2'b00, shift_q[9:2]};
          sym_d   = sym_q + 3'd1;
          if (sym_valid(shift_q[3:2]) && (sym_q < 3'd4)) begin
            state_d = SPACE;
            cnt_d   = LEN1;
          end else begin
            state_d = CHAR_GAP;
            cnt_d   = LEN3;
            ichar_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SPACE: begin
        if (cnt_q == '0) begin
          state_d = MARK;
          cnt_d   = mark_len(shift_q[1:0]);
          dot_d   = (shift_q[1:0] == 2'b01);
          dash_d  = (shift_q[1:0] == 2'b10);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cmpl_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    key_d   = (state_d == MARK);
    ready_d = (state_d == IDLE);
  end

  // State, counter, shift register and output registers; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      sym_q   <= '0;
      ready_q <= 1'b1;
      key_q   <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      ichar_q <= 1'b0;
      iword_q <= 1'b0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sym_q   <= sym_d;
      ready_q <= ready_d;
      key_q   <= key_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      ichar_q <= ichar_d;
      iword_q <= iword_d;
      cmpl_q  <= cmpl_d;
    end
  end

  assign ready     = ready_q;
  assign key       = key_q;
  assign dot       = dot_q;
  assign dash      = dash_q;
  assign interchar = ichar_q;
  assign interword = iword_q;
  assign complete  = cmpl_q;

endmodule

// File: tb/tb_morse_sender.sv
// tb/tb_morse_sender.sv - self-checking bench for morse_sender against a waveform model
module tb_morse_sender;

  localparam int U = 4;
  // Output vector order: {ready, key, dot, dash, interchar, interword, complete}
  localparam logic [6:0] IDLE_V = 7'b1000000;
  localparam logic [6:0] CMPL_V = 7'b1000001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [9:0] data_in = 10'd0;
  logic       ready, key, dot, dash, interchar, interword, complete;
  logic [6:0] act;

  logic [6:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         run = 1'b0;

  int  len, hi;
  bit  acc;

  always #5 clk = ~clk;

  morse_sender #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .reset(reset), .send(send), .data_in(data_in),
    .ready(ready), .key(key), .dot(dot), .dash(dash),
    .interchar(interchar), .interword(interword), .complete(complete)
  );

  assign act = {ready, key, dot, dash, interchar, interword, complete};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Expected per-cycle outputs for one character, starting with the cycle after acceptance.
  task automatic gen(input logic [9:0] d, output int n, output int khigh);
    int n0;
    int nsym;
    int ml;
    logic [1:0] s;
    n0 = exp_q.size();
    nsym = 0;
    khigh = 0;
    if (d == 10'd0) begin
      for (int i = 0; i < 7 * U; i++) exp_q.push_back((i == 0) ? 7'b0000010 : 7'b0000000);
    end else begin
      for (int i = 0; i < 5; i++) begin
        s = d[2*i +: 2];
        if (!(s == 2'b01 || s == 2'b10)) break;
        if (nsym > 0)
          for (int j = 0; j < U; j++) exp_q.push_back(7'b0000000);
        ml = (s == 2'b10) ? 3 * U : U;
        for (int j = 0; j < ml; j++)
          exp_q.push_back({1'b0, 1'b1, (j == 0) && (s == 2'b01), (j == 0) && (s == 2'b10), 3'b000});
        khigh += ml;
        nsym++;
      end
      if (nsym > 0)
        for (int j = 0; j < 3 * U; j++) exp_q.push_back((j == 0) ? 7'b0000100 : 7'b0000000);
    end
    exp_q.push_back(CMPL_V);
    n = exp_q.size() - n0;
  endtask

  // Drives send for one edge; the model accepts only if nothing is still playing.
  task automatic send_char(input logic [9:0] d, output int n, output int khigh, output bit a);
    n = 0;
    khigh = 0;
    send = 1'b1;
    data_in = d;
    @(posedge clk);
    a = (exp_q.size() == 0);
    if (a) gen(d, n, khigh);
    #1;
    send = 1'b0;
    data_in = 10'h3FF;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (exp_q.size() != 0 && t < 300);
    check({nm, "_timeout"}, exp_q.size(), 0);
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (run) begin
      logic [6:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_V;
      check($sformatf("cycle_t%0t", $time), act, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", act, IDLE_V);
    reset = 1'b0;
    run = 1'b1;

    @(negedge clk); #1;
    send_char(10'b0000000001, len, hi, acc);
    check("E_len", len, 17);
    check("E_keyhigh", hi, 4);
    wait_done("E");

    @(negedge clk); #1;
    send_char(10'b0000001001, len, hi, acc);
    check("A_len", len, 33);
    check("A_keyhigh", hi, 16);
    wait_done("A");

    @(negedge clk); #1;
    send_char(10'b0000000000, len, hi, acc);
    check("space_len", len, 29);
    wait_done("space");

    @(negedge clk); #1;
    send_char(10'b1010101010, len, hi, acc);
    check("zero_len", len, 89);
    check("zero_keyhigh", hi, 60);
    wait_done("zero");
    send_char(10'b0000000001, len, hi, acc);
    check("b2b_accept", acc, 1);
    check("b2b_len", len, 17);
    wait_done("b2b");

    @(negedge clk); #1;
    send_char(10'b0000000111, len, hi, acc);
    check("invalid_len", len, 1);
    wait_done("invalid");

    @(negedge clk); #1;
    send_char(10'b0000001001, len, hi, acc);
    repeat (2) @(negedge clk);
    #1;
    send_char(10'b0000000001, len, hi, acc);
    check("ignored_accept", acc, 0);
    wait_done("ignored");

    @(negedge clk); #1;
    send_char(10'b0000001001, len, hi, acc);
    repeat (11) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_key", key, 0);
    check("async_ready", ready, 1);
    check("async_all", act, IDLE_V);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk); #1;
    send_char(10'b0000000001, len, hi, acc);
    check("after_reset_len", len, 17);
    wait_done("after_reset");

    repeat (3) @(negedge clk);
    #1;
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
